// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller and its neighbours
// (forwarding unit, pipeline registers).
//   - M-field bit indices (EX/MEM memory/branch control)
//   - WB-field bit indices (write-back control)
//   - hazard FSM state encoding
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // M field
    localparam int MEM_WRITE   = 0;
    localparam int MEM_READ    = 1;
    localparam int BRANCH_FLIP = 2;
    localparam int BRANCH      = 3;

    // WB field
    localparam int REG_WRITE   = 0;
    localparam int MEM_TO_REG  = 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags when the load sitting in
// ID/EX writes a register that the instruction in ID reads. Register 0 is
// hard-wired to zero, so a load targeting it never creates a dependency.
// Ports:
//   idex_memread  in   ID/EX MemRead bit
//   idex_rt       in   load destination held in ID/EX
//   id_rs, id_rt  in   source registers of the instruction in ID
//   load_use      out  dependency detected
// -----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  load_use
);

    assign load_use = idex_memread
                    & (idex_rt != '0)
                    & ((idex_rt == id_rs) | (idex_rt == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Detects load-use
// hazards at ID, services taken branches from EX/MEM and holds the pipeline
// while a multi-cycle data-memory access is outstanding.
//
// Optional build macro: PIPE_CTRL_STATS_EN adds saturating stall/flush
// statistics outputs.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   id_rs, id_rt        ID source registers
//   idex_memread/_rt    load in ID/EX
//   exmem_m, exmem_zero EX/MEM M field and zero flag
//   mem_ready           data memory completion pulse
//   pc_write            PC update enable
//   *_hold / *_flush    pipeline register hold / clear-to-NOP
//   pc_src              select branch target
//   mem_start, mem_err  access request pulse, timeout pulse
//   stall_cycles, flush_count  (PIPE_CTRL_STATS_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RUN      | normal flow; load-use stall, branch service, memory entry
// MEM_WAIT | pipeline frozen until mem_ready or timeout
// BR_FLUSH | cycle after a branch flush; ID holds a NOP so hazards ignored
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4     // 2**CNT_W must exceed MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [3:0]            exmem_m,
    input  logic                  exmem_zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ifid_hold,
    output logic                  idex_hold,
    output logic                  exmem_hold,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  pc_src,
    output logic                  mem_start,
    output logic                  mem_err
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_count
`endif
);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic br_taken;
    logic mem_acc;
    logic load_use;
    logic ifid_hold_req, idex_hold_req, exmem_hold_req;

    assign br_taken = exmem_m[BRANCH] & (exmem_zero ^ exmem_m[BRANCH_FLIP]);
    assign mem_acc  = exmem_m[MEM_WRITE] | exmem_m[MEM_READ];

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .load_use     (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded outputs are forced to the RUN/no-hazard values while reset is
    // asserted so the pipeline is released immediately, even if EX/MEM still
    // holds a memory instruction.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write       = 1'b1;
        ifid_hold_req  = 1'b0;
        idex_hold_req  = 1'b0;
        exmem_hold_req = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        pc_src         = 1'b0;
        mem_start      = 1'b0;
        mem_err        = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (mem_acc) begin
                        state_d        = MEM_WAIT;
                        cnt_d          = '0;
                        mem_start      = 1'b1;
                        pc_write       = 1'b0;
                        ifid_hold_req  = 1'b1;
                        idex_hold_req  = 1'b1;
                        exmem_hold_req = 1'b1;
                    end else if (br_taken) begin
                        state_d     = BR_FLUSH;
                        pc_src      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write      = 1'b0;
                        ifid_hold_req = 1'b1;
                        idex_flush    = 1'b1;
                    end
                end

                // Counter equals the number of wait cycles already spent, so
                // the access is abandoned on the cycle after MEM_TIMEOUT full
                // wait cycles without a response.
                MEM_WAIT: begin
                    pc_write       = 1'b0;
                    ifid_hold_req  = 1'b1;
                    idex_hold_req  = 1'b1;
                    exmem_hold_req = 1'b1;
                    cnt_d          = cnt_q + 1'b1;
                    if (mem_ready) begin
                        cnt_d   = '0;
                        state_d = RUN;
                        // Branch that rode along with the memory op is
                        // serviced now that the access has finished.
                        if (br_taken) begin
                            state_d     = BR_FLUSH;
                            pc_write    = 1'b1;
                            pc_src      = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                        cnt_d   = '0;
                        state_d = RUN;
                        mem_err = 1'b1;
                    end
                end

                BR_FLUSH: begin
                    state_d = RUN;
                end

                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Flush wins over hold on the same register.
    assign ifid_hold  = ifid_hold_req  & ~ifid_flush;
    assign idex_hold  = idex_hold_req  & ~idex_flush;
    assign exmem_hold = exmem_hold_req & ~exmem_flush;

`ifdef PIPE_CTRL_STATS_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state_q == MEM_WAIT)
                     | ((state_q == RUN) & ~mem_acc & ~br_taken & load_use);
    assign flush_inc = pc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (flush_inc && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed self-checking bench for pipe_hazard_ctrl. Inputs change 1 ns after
// the rising edge, outputs are sampled 2 ns later. Control outputs are packed
// as {pc_write, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
// exmem_flush, pc_src, mem_start, mem_err}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [9:0] C_IDLE  = 10'b1000000000;
    localparam logic [9:0] C_LU    = 10'b0100010000;
    localparam logic [9:0] C_BR    = 10'b1000111100;
    localparam logic [9:0] C_ENTRY = 10'b0111000010;
    localparam logic [9:0] C_WAIT  = 10'b0111000000;
    localparam logic [9:0] C_ERR   = 10'b0111000001;

    logic                  clk;
    logic                  rst_n;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, idex_rt;
    logic                  idex_memread;
    logic [3:0]            exmem_m;
    logic                  exmem_zero;
    logic                  mem_ready;
    logic pc_write, ifid_hold, idex_hold, exmem_hold;
    logic ifid_flush, idex_flush, exmem_flush, pc_src, mem_start, mem_err;
`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    logic [9:0] ctl;
    assign ctl = {pc_write, ifid_hold, idex_hold, exmem_hold, ifid_flush,
                  idex_flush, exmem_flush, pc_src, mem_start, mem_err};

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .exmem_m      (exmem_m),
        .exmem_zero   (exmem_zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_hold    (ifid_hold),
        .idex_hold    (idex_hold),
        .exmem_hold   (exmem_hold),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .pc_src       (pc_src),
        .mem_start    (mem_start),
        .mem_err      (mem_err)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        id_rs        = '0;
        id_rt        = '0;
        idex_memread = 1'b0;
        idex_rt      = '0;
        exmem_m      = 4'b0000;
        exmem_zero   = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic stats_check(input string tag);
`ifdef PIPE_CTRL_STATS_EN
        check_val({tag, "_stall"}, stall_cycles, 16'(exp_stall));
        check_val({tag, "_flush"}, flush_count, 16'(exp_flush));
`else
        if (tag.len() == 0) $display("empty stats tag");
`endif
    endtask

    // Memory access: entry cycle in RUN, then wait cycles k=0.. until
    // mem_ready at k==ready_at (ready_at<0: never) or timeout at k==15.
    task automatic run_mem(input string tag, input logic [3:0] m,
                           input logic zero, input int ready_at,
                           input bit br_exit);
        exmem_m    = m;
        exmem_zero = zero;
        settle();
        check_val({tag, "_entry"}, 16'(ctl), 16'(C_ENTRY));
        for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            tick();
            mem_ready = (k == ready_at);
            settle();
            exp_stall++;
            if (k == ready_at) begin
                check_val({tag, "_exit"}, 16'(ctl), br_exit ? 16'(C_BR) : 16'(C_WAIT));
                if (br_exit) exp_flush++;
                break;
            end else if (k == MEM_TIMEOUT) begin
                check_val({tag, "_timeout"}, 16'(ctl), 16'(C_ERR));
                break;
            end else begin
                check_val({tag, "_wait"}, 16'(ctl), 16'(C_WAIT));
            end
        end
        tick();
        clear_inputs();
        settle();
        check_val({tag, "_after"}, 16'(ctl), 16'(C_IDLE));
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check_val("reset_ctl", 16'(ctl), 16'(C_IDLE));
        stats_check("reset");
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check_val("run_idle", 16'(ctl), 16'(C_IDLE));

        // Load-use on rs
        tick();
        idex_memread = 1'b1; idex_rt = 5'd3; id_rs = 5'd3; id_rt = 5'd7;
        settle();
        check_val("lu_rs", 16'(ctl), 16'(C_LU));
        exp_stall++;
        tick();
        clear_inputs();
        settle();
        check_val("lu_after", 16'(ctl), 16'(C_IDLE));

        // Load to r0 is not a hazard
        tick();
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        settle();
        check_val("lu_r0", 16'(ctl), 16'(C_IDLE));

        // Load-use on rt; same regs without MemRead is no hazard
        tick();
        idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5;
        settle();
        check_val("lu_rt", 16'(ctl), 16'(C_LU));
        exp_stall++;
        tick();
        idex_memread = 1'b0;
        settle();
        check_val("lu_no_memread", 16'(ctl), 16'(C_IDLE));
        clear_inputs();

        // Branch taken (zero=1); load-use ignored in BR_FLUSH, seen after
        tick();
        exmem_m = 4'b1000; exmem_zero = 1'b1;
        settle();
        check_val("br_taken", 16'(ctl), 16'(C_BR));
        exp_flush++;
        tick();
        clear_inputs();
        idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
        settle();
        check_val("br_flush_state", 16'(ctl), 16'(C_IDLE));
        tick();
        settle();
        check_val("lu_after_brflush", 16'(ctl), 16'(C_LU));
        exp_stall++;
        tick();
        clear_inputs();

        // Flipped branch: zero=1 not taken, zero=0 taken
        exmem_m = 4'b1100; exmem_zero = 1'b1;
        settle();
        check_val("brflip_not_taken", 16'(ctl), 16'(C_IDLE));
        tick();
        exmem_zero = 1'b0;
        settle();
        check_val("brflip_taken", 16'(ctl), 16'(C_BR));
        exp_flush++;
        tick();
        clear_inputs();
        settle();
        check_val("brflip_flush_state", 16'(ctl), 16'(C_IDLE));
        tick();

        // Memory read, ready on third wait cycle -> 4 hold cycles
        run_mem("mem_rd", 4'b0010, 1'b0, 2, 1'b0);
        tick();
        // Memory write, never ready -> timeout
        run_mem("mem_to", 4'b0001, 1'b0, -1, 1'b0);
        tick();
        // Ready coincides with timeout cycle -> no error
        run_mem("mem_to_rdy", 4'b0001, 1'b0, MEM_TIMEOUT, 1'b0);
        tick();
        // Memory op plus taken branch: access first, flush on exit
        run_mem("mem_br", 4'b1010, 1'b1, 1, 1'b1);
        tick();
        settle();
        check_val("mem_br_run", 16'(ctl), 16'(C_IDLE));
        stats_check("pre_reset");

        // Async reset in the middle of MEM_WAIT
        tick();
        exmem_m = 4'b0010;
        settle();
        check_val("rst_entry", 16'(ctl), 16'(C_ENTRY));
        tick();
        tick();
        settle();
        check_val("rst_wait", 16'(ctl), 16'(C_WAIT));
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_ctl", 16'(ctl), 16'(C_IDLE));
        exp_stall = 0;
        exp_flush = 0;
        stats_check("rst_async");
        tick();
        clear_inputs();
        rst_n = 1'b1;
        tick();
        // Counter must have restarted from zero: full timeout again
        run_mem("post_rst_to", 4'b0010, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 8-bit pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards at ID, resolves branches at the EX/MEM boundary, and holds the pipeline while a multi-cycle data-memory access completes.
- Drives the PC write enable, the per-register hold/flush controls and the branch PC-select.
- Single FSM; all outputs are registered or decoded from state plus the current inputs (see Behaviour).

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MEM_TIMEOUT, 15, maximum cycles spent in MEM_WAIT before the access is abandoned.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  REG_ADDR_W  source register A of the instruction in ID.
- id_rt  in  REG_ADDR_W  source register B of the instruction in ID.
- idex_memread  in  1  ID/EX M-field MemRead bit.
- idex_rt  in  REG_ADDR_W  load destination register held in ID/EX.
- exmem_m  in  4  EX/MEM M field: bit0 MemWrite, bit1 MemRead, bit2 BranchFlip, bit3 Branch.
- exmem_zero  in  1  EX/MEM zero flag.
- mem_ready  in  1  data memory has completed the access (1-cycle pulse).
- pc_write  out  1  PC update enable.
- ifid_hold  out  1  IF/ID hold.
- idex_hold  out  1  ID/EX hold.
- exmem_hold  out  1  EX/MEM hold.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_flush  out  1  ID/EX clear to NOP (bubble insertion).
- exmem_flush  out  1  EX/MEM control fields cleared.
- pc_src  out  1  select the branch target for the next PC.
- mem_start  out  1  1-cycle access-request pulse to data memory.
- mem_err  out  1  1-cycle pulse when an access times out.

Behaviour:
- Reset (rst_n=0): state=RUN, counter=0, all registered outputs 0; pc_write=1 and all holds/flushes 0 as decoded in RUN.
- Derived signals:
  - br_taken = exmem_m[3] & (exmem_zero ^ exmem_m[2]).
  - mem_acc = exmem_m[0] | exmem_m[1].
  - load_use = idex_memread & idex_rt != 0 & (idex_rt == id_rs | idex_rt == id_rt).
- States: RUN, MEM_WAIT, BR_FLUSH.
- RUN, priority order:
  1. mem_acc: go to MEM_WAIT, pulse mem_start this cycle, assert all holds, pc_write=0.
  2. br_taken: pc_src=1, ifid_flush=idex_flush=exmem_flush=1 for one cycle, go to BR_FLUSH.
  3. load_use: pc_write=0, ifid_hold=1, idex_flush=1 for one cycle, stay in RUN.
  4. Otherwise: pc_write=1, no holds or flushes.
- MEM_WAIT: all holds=1, pc_write=0, counter increments each cycle.
  - mem_ready: counter cleared, return to RUN. If br_taken, execute the branch flush in the same exit cycle, so a branch that coincides with a memory op is serviced after the access.
  - counter==MEM_TIMEOUT with no mem_ready: mem_err pulses 1 cycle, return to RUN.
  - mem_ready and timeout in the same cycle: mem_ready wins, no mem_err.
- BR_FLUSH: one cycle, pc_write=1, no flushes (the flushed EX/MEM now holds a NOP), return to RUN. A load_use in this cycle is ignored because IF/ID was flushed.
- mem_start never re-asserts while in MEM_WAIT; each memory instruction produces exactly one pulse.
- Flush has priority over hold on the same register.
- Reset mid-MEM_WAIT: immediate return to RUN, counter=0, no mem_err.

Optional Feature:
- Macro PIPE_CTRL_STATS_EN.
- Defined: adds outputs stall_cycles[15:0] (load-use plus MEM_WAIT cycles) and flush_count[15:0] (taken branches). Both are saturating, reset to 0 and cleared only by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - M-field bit indices: MEM_WRITE=0, MEM_READ=1, BRANCH_FLIP=2, BRANCH=3.
  - WB-field bit indices: REG_WRITE=0, MEM_TO_REG=1.
  - FSM state enumeration.
- One sub-module, hazard_detect: purely combinational load_use comparator, reusable by the forwarding unit.

Test Plan:
- Load-use: idex_memread=1, idex_rt=3, id_rs=3 -> one cycle with pc_write=0, ifid_hold=1, idex_flush=1, then normal flow. Same stimulus with idex_rt=0 -> no stall.
- Branch: exmem_m=4'b1000, zero=1 -> pc_src=1 and three flushes for 1 cycle, then BR_FLUSH, then RUN. With exmem_m=4'b1100, zero=1 -> not taken. With exmem_m=4'b1100, zero=0 -> taken.
- Memory wait: exmem_m=4'b0010, mem_ready after 3 cycles -> mem_start is a single pulse, holds asserted for exactly 4 cycles including the entry cycle, then release.
- Timeout: exmem_m=4'b0001, mem_ready never asserted -> mem_err pulses after 15 wait cycles, return to RUN. Variant with mem_ready arriving on the timeout cycle -> no mem_err.
- Priority: mem_acc and br_taken in the same cycle -> memory access completes first, branch flush occurs on the mem_ready exit cycle.
- Async reset asserted mid-MEM_WAIT -> outputs return to reset values before the next clk edge; with PIPE_CTRL_STATS_EN defined, counters read 0.
